// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering memRead/memWrite level strobes with one access per strobe.
// Optional macro DMEM_ALIGN_CHECK_EN: reject byte addresses that are not word aligned.
module data_mem_responder #(
  parameter int    ADDR_W      = 8,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          wait_cnt_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [31:0]         wdata_r;
  logic                is_write_r;
  logic                reject_r;
  logic                req_s;
  logic                out_of_range_s;
  logic                misalign_s;
  logic                reject_s;
  logic [31:0]         rd_word_s;
  logic [31:0]         mem_r [DEPTH];

  assign req_s          = rd_en | wr_en;
  assign out_of_range_s = |addr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_s = |addr[1:0];
`else
  // Byte offset is ignored: the access goes to the containing word.
  logic unused_byte_offset_s;
  assign unused_byte_offset_s = ^addr[1:0];
  assign misalign_s           = 1'b0;
`endif

  assign reject_s  = (rd_en & wr_en) | out_of_range_s | misalign_s;
  assign rd_word_s = mem_r[idx_r];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; strobes are only looked at in IDLE and HOLD.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          state_s = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s = S_ACCESS;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_ACCESS: state_s = S_HOLD;
      S_HOLD: begin
        if (!req_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Request capture, wait counting and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 4'd0;
      idx_r      <= '0;
      wdata_r    <= 32'd0;
      is_write_r <= 1'b0;
      reject_r   <= 1'b0;
      rd_data    <= 32'd0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req_s) begin
            idx_r      <= addr[ADDR_W+1:2];
            wdata_r    <= wr_data;
            is_write_r <= wr_en;
            reject_r   <= reject_s;
            wait_cnt_r <= 4'd0;
            busy       <= 1'b1;
          end
        end
        S_WAIT: wait_cnt_r <= wait_cnt_r + 4'd1;
        S_ACCESS: begin
          done <= 1'b1;
          err  <= reject_r;
          if (!reject_r && !is_write_r) begin
            rd_data <= rd_word_s;
          end
        end
        S_HOLD: begin
          if (!req_s) begin
            busy <= 1'b0;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_r == S_ACCESS && is_write_r && !reject_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder (ADDR_W=8, WAIT_CYCLES=2) with a word-array model.
module tb_data_mem_responder;

  localparam int W = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        done;
  logic        busy;
  logic        err;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          done_cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mm [0:255];
  logic [31:0] exp_rd = 32'd0;
  int          total = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse consumes exactly one expected response.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("err", 32'(err), 32'(mon_e.err));
        check("rd_data", rd_data, mon_e.rd);
        check("done_latency", 32'(cyc), 32'(mon_e.done_cyc));
      end
    end
    if (rst_n && err && !done) check("err_without_done", 32'(err), 32'd0);
  end

  // One request: strobes held for h sampling edges, other inputs scrambled after capture.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int h);
    exp_t e;
    bit   rej;
    int   cap;
    int   fall;
    @(negedge clk);
    rd_en = rd; wr_en = wr; addr = a; wr_data = d;
    cap = cyc + 1;
    rej = (rd && wr) || (a[31:10] != 22'd0) || (ALIGN_CHK && a[1:0] != 2'd0);
    if (!rej && rd) exp_rd = mm[a[9:2]];
    if (!rej && wr) mm[a[9:2]] = d;
    e.err = rej; e.rd = exp_rd; e.done_cyc = cap + 1 + W;
    sbq.push_back(e);
    fall = cap + ((h > 2 + W) ? h : 2 + W);
    while (cyc < fall) begin
      @(negedge clk);
      if (cyc == cap + h - 1) begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
      addr = $urandom; wr_data = $urandom;
      if (cyc == fall - 1) check("busy_held", 32'(busy), 32'd1);
    end
    check("busy_released", 32'(busy), 32'd0);
  endtask

  initial begin
    bit          rd;
    bit          wr;
    logic [31:0] a;
    int          r;

    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) do_op(1'b0, 1'b1, 32'(i * 4), $urandom, $urandom_range(1, 3));

    do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2);
    do_op(1'b1, 1'b0, 32'h10, 32'h0, 1);
    do_op(1'b1, 1'b1, 32'h20, 32'h1234, 1);
    do_op(1'b1, 1'b0, 32'h20, 32'h0, 1);
    do_op(1'b1, 1'b0, 32'h400, 32'h0, 1);
    do_op(1'b0, 1'b1, 32'h400, 32'h11111111, 3);
    do_op(1'b0, 1'b1, 32'h12, 32'h5555AAAA, 1);
    do_op(1'b1, 1'b0, 32'h10, 32'h0, 1);
    do_op(1'b1, 1'b0, 32'h14, 32'h0, 5);
    do_op(1'b1, 1'b0, 32'h14, 32'h0, 8);
    do_op(1'b1, 1'b0, 32'h3FC, 32'h0, 1);

    // Reset during the wait phase of a write must not touch the word.
    @(negedge clk);
    wr_en = 1'b1; addr = 32'h40; wr_data = 32'hCAFEF00D;
    @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rd_data", rd_data, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    exp_rd = 32'd0;
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 1);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      a = (r == 8) ? $urandom : 32'($urandom_range(0, 1023));
      do_op(rd, wr, a, $urandom, $urandom_range(1, 7));
    end

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
